can_register_file: RTL and testbench

Parametrised register bank for the CAN FD receiver's host-visible control/status space. It holds DEPTH registers of WIDTH bits behind a simple address-decoded write port and a registered read port. Each bit is either software read/write or a sticky hardware-set / software write-one-to-clear status bit. The bank provides a synchronous clear, a combined interrupt flag and, optionally, shadow double-buffering of the control bits.

---
 rtl/can_reg_if.sv | 29 ++
 rtl/can_register_file.sv | 104 ++++++++++
 tb/tb_can_register_file.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/can_reg_if.sv
// Host-side bus bundle for can_register_file: write port, read port, status set
// pulses, shadow commit and the active register image / interrupt back to the core.
interface can_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
);
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [WIDTH-1:0]         wdata;
  logic                     re;
  logic [AW-1:0]            raddr;
  logic [WIDTH-1:0]         rdata;
  logic                     rvalid;
  logic [DEPTH*WIDTH-1:0]   hw_set;
  logic                     commit;
  logic [DEPTH*WIDTH-1:0]   data_out;
  logic                     irq;

  modport master (
    output we, waddr, wdata, re, raddr, hw_set, commit,
    input  rdata, rvalid, data_out, irq
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, hw_set, commit,
    output rdata, rvalid, data_out, irq
  );
endinterface

// File: rtl/can_register_file.sv
// CAN FD receiver control/status register bank: R/W control bits, sticky W1C status bits.
// Optional shadow double-buffering of control bits when CAN_REG_SHADOW_EN is defined.
module can_register_file #(
  parameter int unsigned            WIDTH       = 8,
  parameter int unsigned            DEPTH       = 4,
  parameter int unsigned            AW          = 2,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DEPTH*WIDTH-1:0] W1C_MASK    = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rst_sync,
  can_reg_if.slave   bus
);
  localparam int unsigned NB = DEPTH * WIDTH;

  logic [NB-1:0]    act_q;
  logic [NB-1:0]    act_d;
  logic [NB-1:0]    wr_mask_c;
  logic [NB-1:0]    wdata_rep_c;
  logic [NB-1:0]    sts_d;
  logic [NB-1:0]    ctrl_d;
  logic [NB-1:0]    view_c;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             rvalid_q;

  assign wdata_rep_c = {DEPTH{bus.wdata}};

  // Per-bit write enable; out-of-range addresses never match a register
  always_comb begin : write_decode
    wr_mask_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.we && (bus.waddr == AW'(i))) begin
        wr_mask_c[i*WIDTH +: WIDTH] = '1;
      end
    end
  end

  // Set wins over a same-cycle clear so no hardware event is lost
  assign sts_d = ((act_q & ~(wr_mask_c & wdata_rep_c)) | bus.hw_set) & W1C_MASK;

`ifdef CAN_REG_SHADOW_EN
  logic [NB-1:0] shd_q;
  logic [NB-1:0] shd_d;

  assign shd_d  = ((wr_mask_c & wdata_rep_c) | (~wr_mask_c & shd_q)) & ~W1C_MASK;
  // Commit uses shd_d so a write in the commit cycle lands in active directly
  assign ctrl_d = bus.commit ? shd_d : (act_q & ~W1C_MASK);
  assign view_c = shd_q | (act_q & W1C_MASK);

  always_ff @(posedge clk or negedge rst_n) begin : shadow_reg
    if (!rst_n) begin
      shd_q <= RESET_VALUE & ~W1C_MASK;
    end else if (rst_sync) begin
      shd_q <= RESET_VALUE & ~W1C_MASK;
    end else begin
      shd_q <= shd_d;
    end
  end
`else
  logic unused_commit;

  assign unused_commit = bus.commit;
  assign ctrl_d = ((wr_mask_c & wdata_rep_c) | (~wr_mask_c & act_q)) & ~W1C_MASK;
  assign view_c = act_q;
`endif

  assign act_d = sts_d | ctrl_d;

  // Read mux returns zero for addresses beyond DEPTH
  always_comb begin : read_mux
    rdata_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.raddr == AW'(i)) begin
        rdata_d = view_c[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      act_q    <= RESET_VALUE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (rst_sync) begin
      act_q    <= RESET_VALUE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      rvalid_q <= bus.re;
      if (bus.re) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign bus.data_out = act_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.irq      = |(act_q & W1C_MASK);

endmodule

// File: tb/tb_can_register_file.sv
// Directed bench for can_register_file: a DEPTH=4 bank with status nibble in reg0
// and a DEPTH=3 bank for out-of-range addressing.
module tb_can_register_file;
`ifdef CAN_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rst_sync;
  int   checks;
  int   failures;

  can_reg_if #(.WIDTH(8), .DEPTH(4), .AW(2)) if4 ();
  can_reg_if #(.WIDTH(8), .DEPTH(3), .AW(2)) if3 ();

  can_register_file #(
    .WIDTH(8), .DEPTH(4), .AW(2),
    .RESET_VALUE(32'h0000_5A00), .W1C_MASK(32'h0000_000F)
  ) u4 (.clk(clk), .rst_n(rst_n), .rst_sync(rst_sync), .bus(if4));

  can_register_file #(
    .WIDTH(8), .DEPTH(3), .AW(2),
    .RESET_VALUE(24'h0), .W1C_MASK(24'h0)
  ) u3 (.clk(clk), .rst_n(rst_n), .rst_sync(rst_sync), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_sync = 1'b0;
    if4.we = 1'b0; if4.waddr = '0; if4.wdata = '0; if4.re = 1'b0; if4.raddr = '0;
    if4.hw_set = '0; if4.commit = 1'b0;
    if3.we = 1'b0; if3.waddr = '0; if3.wdata = '0; if3.re = 1'b0; if3.raddr = '0;
    if3.hw_set = '0; if3.commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    checks++; if (if4.data_out !== 32'h0000_5A00) begin failures++; $display("FAIL reset_data_out got %h exp %h", if4.data_out, 32'h0000_5A00); end
    checks++; if (if4.rvalid !== 1'b0 || if4.rdata !== 8'h00) begin failures++; $display("FAIL reset_read got rvalid=%b rdata=%h exp 0/00", if4.rvalid, if4.rdata); end
    checks++; if (if4.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", if4.irq); end
    rst_n = 1'b1;
    tick();
    if4.re = 1'b1; if4.raddr = 2'd1;
    tick();
    if4.re = 1'b0;
    checks++; if (if4.rvalid !== 1'b1 || if4.rdata !== 8'h5A) begin failures++; $display("FAIL reset_readback got rvalid=%b rdata=%h exp 1/5a", if4.rvalid, if4.rdata); end
    checks++; if (if4.data_out[15:8] !== 8'h5A) begin failures++; $display("FAIL reset_reg1 got %h exp 5a", if4.data_out[15:8]); end
    tick();
    checks++; if (if4.rvalid !== 1'b0 || if4.rdata !== 8'h5A) begin failures++; $display("FAIL rvalid_pulse got rvalid=%b rdata=%h exp 0/5a", if4.rvalid, if4.rdata); end
  endtask

  task automatic test_write_rbw();
    logic [7:0] exp;
    if4.we = 1'b1; if4.waddr = 2'd2; if4.wdata = 8'h3C;
    if4.re = 1'b1; if4.raddr = 2'd2;
    tick();
    if4.we = 1'b0;
    exp = SHADOW ? 8'h00 : 8'h3C;
    checks++; if (if4.rvalid !== 1'b1 || if4.rdata !== 8'h00) begin failures++; $display("FAIL rbw_old got rvalid=%b rdata=%h exp 1/00", if4.rvalid, if4.rdata); end
    checks++; if (if4.data_out[23:16] !== exp) begin failures++; $display("FAIL write_active got %h exp %h", if4.data_out[23:16], exp); end
    tick();
    if4.re = 1'b0;
    checks++; if (if4.rdata !== 8'h3C) begin failures++; $display("FAIL rbw_new got %h exp 3c", if4.rdata); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] addr [4];
    logic [7:0] exp  [4];
    addr = '{2'd0, 2'd3, 2'd2, 2'd1};
    exp  = '{8'h00, 8'h00, 8'h3C, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      if4.re = 1'b1; if4.raddr = addr[i];
      tick();
      checks++; if (if4.rvalid !== 1'b1 || if4.rdata !== exp[i]) begin failures++; $display("FAIL b2b_read%0d got rvalid=%b rdata=%h exp 1/%h", i, if4.rvalid, if4.rdata, exp[i]); end
    end
    if4.re = 1'b0;
    tick();
    checks++; if (if4.rvalid !== 1'b0 || if4.rdata !== 8'h5A) begin failures++; $display("FAIL b2b_hold got rvalid=%b rdata=%h exp 0/5a", if4.rvalid, if4.rdata); end
  endtask

  task automatic test_depth_bound();
    if3.we = 1'b1; if3.waddr = 2'd0; if3.wdata = 8'h77; if3.commit = 1'b1;
    tick();
    checks++; if (if3.data_out !== 24'h00_0077) begin failures++; $display("FAIL d3_write got %h exp 000077", if3.data_out); end
    if3.waddr = 2'd3; if3.wdata = 8'hFF;
    if3.re = 1'b1; if3.raddr = 2'd0;
    tick();
    checks++; if (if3.rdata !== 8'h77) begin failures++; $display("FAIL d3_read0 got %h exp 77", if3.rdata); end
    if3.we = 1'b0; if3.commit = 1'b0; if3.raddr = 2'd3;
    tick();
    if3.re = 1'b0;
    checks++; if (if3.data_out !== 24'h00_0077) begin failures++; $display("FAIL d3_oob_write got %h exp 000077", if3.data_out); end
    checks++; if (if3.rvalid !== 1'b1 || if3.rdata !== 8'h00) begin failures++; $display("FAIL d3_oob_read got rvalid=%b rdata=%h exp 1/00", if3.rvalid, if3.rdata); end
  endtask

  task automatic test_sticky();
    if4.hw_set = 32'h0100_0001;
    tick();
    if4.hw_set = '0;
    checks++; if (if4.data_out[7:0] !== 8'h01 || if4.irq !== 1'b1) begin failures++; $display("FAIL sticky_set got reg0=%h irq=%b exp 01/1", if4.data_out[7:0], if4.irq); end
    checks++; if (if4.data_out[31:24] !== 8'h00) begin failures++; $display("FAIL hwset_ctrl_ignored got %h exp 00", if4.data_out[31:24]); end
    if4.we = 1'b1; if4.waddr = 2'd0; if4.wdata = 8'hF0; if4.commit = 1'b1;
    tick();
    checks++; if (if4.data_out[7:0] !== 8'hF1 || if4.irq !== 1'b1) begin failures++; $display("FAIL ctrl_nibble got reg0=%h irq=%b exp f1/1", if4.data_out[7:0], if4.irq); end
    if4.wdata = 8'h01;
    tick();
    if4.we = 1'b0; if4.commit = 1'b0;
    checks++; if (if4.data_out[7:0] !== 8'h00 || if4.irq !== 1'b0) begin failures++; $display("FAIL w1c_clear got reg0=%h irq=%b exp 00/0", if4.data_out[7:0], if4.irq); end
  endtask

  task automatic test_set_clear_collision();
    if4.hw_set = 32'h0000_0002;
    if4.we = 1'b1; if4.waddr = 2'd0; if4.wdata = 8'h02; if4.commit = 1'b1;
    tick();
    if4.hw_set = '0;
    checks++; if (if4.data_out[7:0] !== 8'h02 || if4.irq !== 1'b1) begin failures++; $display("FAIL set_wins got reg0=%h irq=%b exp 02/1", if4.data_out[7:0], if4.irq); end
    tick();
    checks++; if (if4.data_out[7:0] !== 8'h00) begin failures++; $display("FAIL clear_after got %h exp 00", if4.data_out[7:0]); end
    rst_sync = 1'b1;
    if4.waddr = 2'd1; if4.wdata = 8'hFF; if4.hw_set = 32'hFFFF_FFFF;
    if4.re = 1'b1; if4.raddr = 2'd1;
    tick();
    idle();
    checks++; if (if4.data_out !== 32'h0000_5A00 || if4.irq !== 1'b0) begin failures++; $display("FAIL rst_sync_state got %h irq=%b exp 00005a00/0", if4.data_out, if4.irq); end
    checks++; if (if4.rvalid !== 1'b0 || if4.rdata !== 8'h00) begin failures++; $display("FAIL rst_sync_read got rvalid=%b rdata=%h exp 0/00", if4.rvalid, if4.rdata); end
    if4.re = 1'b1; if4.raddr = 2'd1;
    tick();
    if4.re = 1'b0;
    checks++; if (if4.rdata !== 8'h5A) begin failures++; $display("FAIL rst_sync_readback got %h exp 5a", if4.rdata); end
  endtask

  task automatic test_shadow();
    logic [7:0] exp;
    if4.we = 1'b1; if4.waddr = 2'd1; if4.wdata = 8'hAA; if4.hw_set = 32'h0000_0001;
    tick();
    if4.we = 1'b0; if4.hw_set = '0;
    exp = SHADOW ? 8'h5A : 8'hAA;
    checks++; if (if4.data_out[15:8] !== exp) begin failures++; $display("FAIL shadow_hold got %h exp %h", if4.data_out[15:8], exp); end
    checks++; if (if4.data_out[7:0] !== 8'h01) begin failures++; $display("FAIL status_unshadowed got %h exp 01", if4.data_out[7:0]); end
    if4.re = 1'b1; if4.raddr = 2'd1;
    tick();
    if4.re = 1'b0;
    checks++; if (if4.rdata !== 8'hAA) begin failures++; $display("FAIL shadow_read got %h exp aa", if4.rdata); end
    if4.commit = 1'b1;
    tick();
    checks++; if (if4.data_out[15:8] !== 8'hAA) begin failures++; $display("FAIL commit got %h exp aa", if4.data_out[15:8]); end
    if4.we = 1'b1; if4.wdata = 8'h55;
    tick();
    idle();
    checks++; if (if4.data_out[15:8] !== 8'h55) begin failures++; $display("FAIL write_commit got %h exp 55", if4.data_out[15:8]); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_rbw();
    test_back_to_back();
    test_depth_bound();
    test_sticky();
    test_set_clear_collision();
    test_shadow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
